// File: rtl/npu_dma_arbiter_if.sv
// Bundle of requester-side and DMA-engine-side signals for npu_dma_arbiter.
// slave  : the arbiter itself.
// master : the cluster environment (requesters plus DMA engine).
interface npu_dma_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 22
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr_i;
  logic [NUM_REQ*SIZE_WIDTH-1:0] req_size_i;
  logic [NUM_REQ*3-1:0]          req_op_i;
  logic [NUM_REQ-1:0]            cpl_valid_o;
  logic                          cpl_error_o;

  // DMA engine side
  logic                          dma_req_o;
  logic [ADDR_WIDTH-1:0]         dma_src_addr_o;
  logic [ADDR_WIDTH-1:0]         dma_dst_addr_o;
  logic [SIZE_WIDTH-1:0]         dma_size_o;
  logic [2:0]                    dma_op_o;
  logic                          dma_done_i;
  logic                          dma_error_i;

  // Status
  logic                          busy_o;
  logic [ID_W-1:0]               grant_id_o;

  modport slave (
    input  req_valid_i, req_src_addr_i, req_dst_addr_i, req_size_i, req_op_i,
    input  dma_done_i, dma_error_i,
    output req_ready_o, cpl_valid_o, cpl_error_o,
    output dma_req_o, dma_src_addr_o, dma_dst_addr_o, dma_size_o, dma_op_o,
    output busy_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_src_addr_i, req_dst_addr_i, req_size_i, req_op_i,
    output dma_done_i, dma_error_i,
    input  req_ready_o, cpl_valid_o, cpl_error_o,
    input  dma_req_o, dma_src_addr_o, dma_dst_addr_o, dma_size_o, dma_op_o,
    input  busy_o, grant_id_o
  );
endinterface

// File: rtl/npu_dma_arbiter.sv
// Round-robin descriptor arbiter/sequencer in front of the NPU cluster DMA engine.
// Grants one requester at a time, issues its descriptor to the engine, waits for
// done/error, then pulses a completion with status back to the owner.
// Optional watchdog on the WAIT state: define NPU_DMA_ARB_TIMEOUT_EN.
module npu_dma_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SIZE_WIDTH     = 22,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  npu_dma_arbiter_if.slave bus
);
  localparam int unsigned   ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [2:0]            op_q, op_d;

`ifdef NPU_DMA_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Per-requester views of the packed descriptor buses
  logic [ADDR_WIDTH-1:0] src_arr  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] dst_arr  [NUM_REQ];
  logic [SIZE_WIDTH-1:0] size_arr [NUM_REQ];
  logic [2:0]            op_arr   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign src_arr[k]  = bus.req_src_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dst_arr[k]  = bus.req_dst_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_arr[k] = bus.req_size_i[k*SIZE_WIDTH +: SIZE_WIDTH];
    assign op_arr[k]   = bus.req_op_i[k*3 +: 3];
  end

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W:0]   cand;
  logic [ID_W:0]   rr_inc;
  logic            win_legal;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && bus.req_valid_i[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Winner legality and the pointer value that follows it
  always_comb begin
    win_legal = (size_arr[win_idx] != '0) && (op_arr[win_idx] <= 3'b010);
    rr_inc    = {1'b0, win_idx} + (ID_W+1)'(1);
    if (rr_inc >= NREQ) rr_inc = '0;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    err_d      = err_q;
    src_d      = src_q;
    dst_d      = dst_q;
    size_d     = size_q;
    op_d       = op_q;
`ifdef NPU_DMA_ARB_TIMEOUT_EN
    wait_cnt_d = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          src_d      = src_arr[win_idx];
          dst_d      = dst_arr[win_idx];
          size_d     = size_arr[win_idx];
          op_d       = op_arr[win_idx];
          grant_id_d = win_idx;
          rr_ptr_d   = rr_inc[ID_W-1:0];
          if (win_legal) begin
            state_d = ISSUE;
            err_d   = 1'b0;
          end else begin
            state_d = CPL;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        err_d   = 1'b0;
      end
      WAIT: begin
`ifdef NPU_DMA_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
        // Engine error outranks done; both outrank the watchdog
        if (bus.dma_error_i) begin
          state_d = CPL;
          err_d   = 1'b1;
        end else if (bus.dma_done_i) begin
          state_d = CPL;
          err_d   = 1'b0;
        end
`ifdef NPU_DMA_ARB_TIMEOUT_EN
        else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = CPL;
          err_d   = 1'b1;
        end
`endif
      end
      CPL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descriptor, ownership and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      size_q     <= '0;
      op_q       <= '0;
`ifdef NPU_DMA_ARB_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      size_q     <= size_d;
      op_q       <= op_d;
`ifdef NPU_DMA_ARB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Outputs decoded from state; ready is gated by reset so it clears asynchronously
  always_comb begin
    bus.req_ready_o = '0;
    if (rst_ni && state_q == IDLE && win_found) bus.req_ready_o[win_idx] = 1'b1;
    bus.cpl_valid_o = '0;
    if (state_q == CPL) bus.cpl_valid_o[grant_id_q] = 1'b1;
    bus.cpl_error_o    = (state_q == CPL) && err_q;
    bus.dma_req_o      = (state_q == ISSUE);
    bus.busy_o         = (state_q != IDLE);
    bus.grant_id_o     = grant_id_q;
    bus.dma_src_addr_o = src_q;
    bus.dma_dst_addr_o = dst_q;
    bus.dma_size_o     = size_q;
    bus.dma_op_o       = op_q;
  end
endmodule

// File: tb/tb_npu_dma_arbiter.sv
// Directed testbench for npu_dma_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_npu_dma_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 22;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int quiet_bad;

  npu_dma_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) bus ();

  npu_dma_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int k, input logic [31:0] src, input logic [31:0] dst,
                          input logic [21:0] size, input logic [2:0] op);
    bus.req_src_addr_i[k*AW +: AW] = src;
    bus.req_dst_addr_i[k*AW +: AW] = dst;
    bus.req_size_i[k*SW +: SW]     = size;
    bus.req_op_i[k*3 +: 3]         = op;
  endtask

  task automatic check_all_clear(input string pfx);
    check({pfx, "_ready"}, bus.req_ready_o, 0);
    check({pfx, "_busy"},  bus.busy_o, 0);
    check({pfx, "_dreq"},  bus.dma_req_o, 0);
    check({pfx, "_cpl"},   bus.cpl_valid_o, 0);
    check({pfx, "_cerr"},  bus.cpl_error_o, 0);
    check({pfx, "_gid"},   bus.grant_id_o, 0);
    check({pfx, "_src"},   bus.dma_src_addr_o, 0);
    check({pfx, "_dst"},   bus.dma_dst_addr_o, 0);
    check({pfx, "_size"},  bus.dma_size_o, 0);
    check({pfx, "_op"},    bus.dma_op_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset, with a requester valid to show ready is held low
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_src_addr_i = '0;
    bus.req_dst_addr_i = '0;
    bus.req_size_i = '0;
    bus.req_op_i = '0;
    bus.dma_done_i = 1'b0;
    bus.dma_error_i = 1'b0;
    set_desc(0, 32'h0000_0100, 32'h0000_0200, 22'd8, 3'b000);
    bus.req_valid_i = 4'b0001;
    #12;
    check_all_clear("rst");
    bus.req_valid_i = '0;
    #10 rst_n = 1'b1;
    tick();

    // Round robin with all four valid, done 5 cycles after issue
    for (int k = 0; k < 4; k++)
      set_desc(k, 32'hA000_0000 + 32'(k) * 32'h100, 32'hB000_0000 + 32'(k) * 32'h100,
               22'(64 * (k + 1)), 3'(k % 3));
    bus.req_valid_i = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_ready", bus.req_ready_o, 64'(1) << exp_order[g]);
      tick();
      check("rr_issue", bus.dma_req_o, 1);
      check("rr_gid",   bus.grant_id_o, exp_order[g]);
      check("rr_src",   bus.dma_src_addr_o, 32'hA000_0000 + 32'(exp_order[g]) * 32'h100);
      check("rr_size",  bus.dma_size_o, 64 * (exp_order[g] + 1));
      repeat (5) tick();
      bus.dma_done_i = 1'b1;
      tick();
      bus.dma_done_i = 1'b0;
      check("rr_cpl",  bus.cpl_valid_o, 64'(1) << exp_order[g]);
      check("rr_cerr", bus.cpl_error_o, 0);
      tick();
    end
    bus.req_valid_i = '0;

    // Illegal: requester 2 with size 0
    set_desc(2, 32'h0000_00C0, 32'h0000_00D0, 22'd0, 3'b001);
    bus.req_valid_i = 4'b0100;
    #1;
    check("sz0_ready", bus.req_ready_o, 4'b0100);
    tick();
    check("sz0_dreq", bus.dma_req_o, 0);
    check("sz0_cpl",  bus.cpl_valid_o, 4'b0100);
    check("sz0_cerr", bus.cpl_error_o, 1);
    check("sz0_gid",  bus.grant_id_o, 2);
    bus.req_valid_i = '0;
    tick();
    check("sz0_busy", bus.busy_o, 0);
    check("sz0_dreq2", bus.dma_req_o, 0);
    check("sz0_cpl2", bus.cpl_valid_o, 0);

    // Illegal: requester 3 with op 011
    set_desc(3, 32'h0000_00E0, 32'h0000_00F0, 22'd16, 3'b011);
    bus.req_valid_i = 4'b1000;
    #1;
    check("op3_ready", bus.req_ready_o, 4'b1000);
    tick();
    check("op3_dreq", bus.dma_req_o, 0);
    check("op3_cpl",  bus.cpl_valid_o, 4'b1000);
    check("op3_cerr", bus.cpl_error_o, 1);
    check("op3_op",   bus.dma_op_o, 3'b011);
    bus.req_valid_i = '0;
    tick();
    check("op3_busy", bus.busy_o, 0);
    check("op3_dreq2", bus.dma_req_o, 0);

    // done and error together in WAIT: error wins
    set_desc(0, 32'h1111_0000, 32'h2222_0000, 22'd256, 3'b000);
    bus.req_valid_i = 4'b0001;
    #1;
    check("de_ready", bus.req_ready_o, 4'b0001);
    tick();
    check("de_issue", bus.dma_req_o, 1);
    bus.req_valid_i = '0;
    tick();
    check("de_wait_busy", bus.busy_o, 1);
    bus.dma_done_i = 1'b1;
    bus.dma_error_i = 1'b1;
    tick();
    bus.dma_done_i = 1'b0;
    bus.dma_error_i = 1'b0;
    check("de_cpl",  bus.cpl_valid_o, 4'b0001);
    check("de_cerr", bus.cpl_error_o, 1);
    tick();
    check("de_idle", bus.busy_o, 0);

    // Spurious done in IDLE is ignored
    bus.dma_done_i = 1'b1;
    tick();
    bus.dma_done_i = 1'b0;
    check("spur_cpl",  bus.cpl_valid_o, 0);
    check("spur_busy", bus.busy_o, 0);
    tick();
    check("spur_cpl2", bus.cpl_valid_o, 0);

    // Lone requester 1, size 1024, op 001, done at cycle 20
    set_desc(1, 32'h1000_0000, 32'h2000_0040, 22'd1024, 3'b001);
    bus.req_valid_i = 4'b0010;
    #1;
    check("t1_ready", bus.req_ready_o, 4'b0010);
    tick();
    check("t1_issue", bus.dma_req_o, 1);
    check("t1_src",   bus.dma_src_addr_o, 32'h1000_0000);
    check("t1_dst",   bus.dma_dst_addr_o, 32'h2000_0040);
    check("t1_size",  bus.dma_size_o, 1024);
    check("t1_op",    bus.dma_op_o, 3'b001);
    check("t1_gid",   bus.grant_id_o, 1);
    check("t1_ready1", bus.req_ready_o, 0);
    bus.req_valid_i = '0;
    quiet_bad = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (bus.dma_req_o !== 1'b0 || bus.cpl_valid_o !== 4'b0000 || bus.busy_o !== 1'b1)
        quiet_bad++;
    end
    check("t1_wait_quiet", quiet_bad, 0);
    bus.dma_done_i = 1'b1;
    tick();
    bus.dma_done_i = 1'b0;
    check("t1_cpl",  bus.cpl_valid_o, 4'b0010);
    check("t1_cerr", bus.cpl_error_o, 0);
    tick();
    check("t1_idle", bus.busy_o, 0);
    check("t1_cpl_end", bus.cpl_valid_o, 0);
    check("t1_hold_src", bus.dma_src_addr_o, 32'h1000_0000);

    // No engine response: watchdog (if built in) or indefinite WAIT
    set_desc(0, 32'h4000_0000, 32'h5000_0000, 22'd32, 3'b000);
    bus.req_valid_i = 4'b0001;
    #1;
    check("to_ready", bus.req_ready_o, 4'b0001);
    tick();
    check("to_issue", bus.dma_req_o, 1);
    bus.req_valid_i = '0;
`ifdef NPU_DMA_ARB_TIMEOUT_EN
    quiet_bad = 0;
    for (int c = 2; c <= 17; c++) begin
      tick();
      if (bus.cpl_valid_o !== 4'b0000 || bus.busy_o !== 1'b1) quiet_bad++;
    end
    check("to_wait_quiet", quiet_bad, 0);
    tick();
    check("to_cpl",  bus.cpl_valid_o, 4'b0001);
    check("to_cerr", bus.cpl_error_o, 1);
    tick();
    check("to_idle", bus.busy_o, 0);
`else
    quiet_bad = 0;
    for (int c = 2; c <= 41; c++) begin
      tick();
      if (bus.cpl_valid_o !== 4'b0000 || bus.busy_o !== 1'b1) quiet_bad++;
    end
    check("nto_wait_quiet", quiet_bad, 0);
    bus.dma_done_i = 1'b1;
    tick();
    bus.dma_done_i = 1'b0;
    check("nto_cpl",  bus.cpl_valid_o, 4'b0001);
    check("nto_cerr", bus.cpl_error_o, 0);
    tick();
    check("nto_idle", bus.busy_o, 0);
`endif

    // Reset dropped during WAIT; rr_ptr is 2 before reset and must restart at 0
    set_desc(1, 32'h3000_0000, 32'h3100_0000, 22'd128, 3'b010);
    bus.req_valid_i = 4'b0010;
    #1;
    check("mr_ready", bus.req_ready_o, 4'b0010);
    tick();
    bus.req_valid_i = '0;
    tick();
    tick();
    check("mr_wait_busy", bus.busy_o, 1);
    set_desc(0, 32'h6000_0000, 32'h6100_0000, 22'd40, 3'b001);
    set_desc(3, 32'h7000_0000, 32'h7100_0000, 22'd48, 3'b000);
    bus.req_valid_i = 4'b1001;
    #2 rst_n = 1'b0;
    #1;
    check_all_clear("mr");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("mr_post_ready", bus.req_ready_o, 4'b0001);
    tick();
    check("mr_post_issue", bus.dma_req_o, 1);
    check("mr_post_gid",   bus.grant_id_o, 0);
    check("mr_post_src",   bus.dma_src_addr_o, 32'h6000_0000);
    bus.req_valid_i = '0;
    tick();
    bus.dma_done_i = 1'b1;
    tick();
    bus.dma_done_i = 1'b0;
    check("mr_post_cpl",  bus.cpl_valid_o, 4'b0001);
    check("mr_post_cerr", bus.cpl_error_o, 0);
    tick();
    check("mr_post_idle", bus.busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/npu_dma_arbiter.md
# npu_dma_arbiter

Round-robin descriptor arbiter and sequencer for the NPU cluster DMA engine. It accepts transfer descriptors from up to NUM_REQ local requesters (compute cores, weight prefetcher, result writeback) and grants one at a time. It drives the engine's single request interface and holds one transfer outstanding until `done`/`error` returns. It then routes a completion pulse with status back to the owning requester. The block sits between the cluster's requesters and the DMA engine request port.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 32: address width, matches DMA engine.
- SIZE_WIDTH, 22: transfer size width in bytes, matches DMA engine.
- TIMEOUT_CYCLES, 4096: watchdog limit while waiting for the engine (used only with the timeout macro).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid_i  in  NUM_REQ  per-requester descriptor valid.
- req_ready_o  out  NUM_REQ  one-hot grant; descriptor accepted when valid&ready.
- req_src_addr_i  in  NUM_REQ*ADDR_WIDTH  packed source addresses, requester k at slice k.
- req_dst_addr_i  in  NUM_REQ*ADDR_WIDTH  packed destination addresses.
- req_size_i  in  NUM_REQ*SIZE_WIDTH  packed sizes in bytes.
- req_op_i  in  NUM_REQ*3  packed ops. Legal values are 000, 001 and 010.
- cpl_valid_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
- cpl_error_o  out  1  status qualifying cpl_valid_o; 1 = failed.
- dma_req_o  out  1  one-cycle request pulse to the engine.
- dma_src_addr_o, dma_dst_addr_o  out  ADDR_WIDTH  registered descriptor addresses.
- dma_size_o  out  SIZE_WIDTH  registered size.
- dma_op_o  out  3  registered op.
- dma_done_i  in  1  engine completion pulse.
- dma_error_i  in  1  engine error pulse.
- busy_o  out  1  high in any state other than IDLE.
- grant_id_o  out  $clog2(NUM_REQ)  index of current owner, valid while busy_o.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CPL.
- **IDLE**
  - Round-robin search over req_valid_i, starting at rr_ptr.
  - The winner's req_ready_o is asserted combinationally in the same cycle.
  - On the accept edge:
    - latch the descriptor into the dma_* registers, set grant_id_o, and set rr_ptr = (winner+1) mod NUM_REQ;
    - go to ISSUE if the descriptor is legal, otherwise go to CPL with err=1.
  - A descriptor is illegal if size==0 or op>010. Illegal descriptors are never issued to the engine.
- **ISSUE**: dma_req_o=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On dma_error_i: go to CPL with err=1.
  - Otherwise, on dma_done_i: go to CPL with err=0.
  - If done and error arrive in the same cycle, error wins.
- **CPL**: cpl_valid_o[grant_id]=1 and cpl_error_o=err for one cycle, then go to IDLE.
- dma_done_i and dma_error_i are ignored outside WAIT.
- req_ready_o is all-zero outside IDLE. Requesters must hold valid and the descriptor stable until accepted.
- rr_ptr advances only on grant. A lone requester can therefore be granted back-to-back.
- Descriptor registers hold their value until the next accept.

## Timing
- Reset values: all outputs 0; rr_ptr=0; state IDLE; descriptor registers 0.
- Accept at edge of cycle 0 → dma_req_o high in cycle 1 → WAIT from cycle 2.
- dma_done_i sampled in cycle N → cpl_valid_o high in cycle N+1 → IDLE in cycle N+2, and a new grant is possible in that cycle.
- Minimum spacing between two grants is 4 cycles plus the engine latency.
- Illegal descriptor: accepted at cycle 0 → cpl_valid_o with cpl_error_o=1 in cycle 1 → IDLE in cycle 2.
- Reset asserted mid-transfer: immediate return to IDLE and all outputs cleared. No completion is generated for the in-flight descriptor; requesters must reissue it after reset.

## Configuration
- Macro: NPU_DMA_ARB_TIMEOUT_EN.
- Defined:
  - a wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle;
  - when it reaches TIMEOUT_CYCLES without done or error, go to CPL with err=1;
  - a done or error arriving in the same cycle as the timeout takes precedence.
- Undefined: no counter, and WAIT persists until the engine responds.

## Test plan
- Single requester 1, size=1024, op=001: ready_o=0010 at cycle 0, dma_req_o pulse at cycle 1 carrying the latched fields, done at cycle 20 → cpl_valid_o=0010 with error=0 at cycle 21.
- All 4 requesters valid continuously, each transfer completed 5 cycles after issue: grant order 0,1,2,3,0; no requester is granted twice before every other valid requester has been granted.
- Requester 2 with size=0, and separately requester 3 with op=011: dma_req_o never asserts; cpl_valid_o pulses for the owner with error=1 one cycle after accept.
- dma_done_i and dma_error_i asserted together in WAIT: error=1 reported. A spurious dma_done_i in IDLE is ignored (no cpl_valid_o).
- rst_ni dropped during WAIT: all outputs 0 asynchronously, FSM in IDLE with rr_ptr=0 after release, and the next request is granted normally.
- With NPU_DMA_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, no engine response: cpl_valid_o with error=1 exactly 16 WAIT cycles after WAIT entry.
